stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencing and arbitration controller for the push-down stack. It accepts push and pop requests, arbitrates between them when both are requested together, and drives the stack-pointer up/down counter's enable and direction plus the synchronous stack RAM's strobes. It owns the full/empty status and reports overflow and underflow errors. It sits between the stack's requesters and the datapath: the stack-pointer counter (BUSWIDTH bits, same `ClrN`) and a single-port RAM with 1-cycle read latency.

## Interface
- `BUSWIDTH`, 10, width of the stack pointer; stack depth = 2^BUSWIDTH entries.
- `Clk`  in  1  rising-edge clock.
- `ClrN`  in  1  asynchronous active-low reset. Shared with the stack-pointer counter, so `Sp` = 0 while `ClrN` = 0.
- `PushReq`  in  1  level push request; sampled only in IDLE.
- `PopReq`  in  1  level pop request; sampled only in IDLE.
- `Sp`  in  BUSWIDTH  current stack-pointer counter output.
- `CntEn`  out  1  stack-pointer counter enable (one-cycle pulse).
- `CntD`  out  1  counter direction: 1 = up, 0 = down.
- `MemWe`  out  1  RAM write strobe at address `Sp`.
- `MemRe`  out  1  RAM read strobe at address `Sp`.
- `Busy`  out  1  high whenever the state is not IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  high with `Done` when the request was rejected (push on full, pop on empty).
- `RdValid`  out  1  high with `Done` when the completed operation is a successful pop; RAM read data is valid in this cycle.
- `Full`  out  1  stack holds 2^BUSWIDTH entries.
- `Empty`  out  1  stack holds 0 entries; `Empty` = (`Sp` == 0) && !`Full`.

## Operation
- States: IDLE, WR, INC, DEC, RD, DONE. Held in registers; all outputs except `Empty` are decoded from registered state and flags.
- Internal registers: `LastPop` (last granted op was a pop), `OpPop` (current op is a pop), `ErrR` (rejected-op flag).
- IDLE, no request: stay in IDLE.
- IDLE, arbitration:
  - Push only: grant the push.
  - Pop only: grant the pop.
  - Both: grant the opposite of `LastPop`. Reset value `LastPop` = 1, so the first contested grant is the push.
  - Every grant updates `LastPop`, including rejected grants.
- Granted push:
  - `Full` = 1: go to DONE with `ErrR` = 1. No `MemWe`, no `CntEn`.
  - Otherwise: WR (`MemWe` = 1), then INC (`CntEn` = 1, `CntD` = 1), then DONE.
- Granted pop:
  - `Empty` = 1: go to DONE with `ErrR` = 1. No `MemRe`, no `CntEn`.
  - Otherwise: DEC (`CntEn` = 1, `CntD` = 0), then RD (`MemRe` = 1, address is the new `Sp`), then DONE.
- DONE:
  - `Done` = 1, `Err` = `ErrR`, `RdValid` = `OpPop` && !`ErrR`.
  - Next state is IDLE unconditionally.
  - The requester drops its request on seeing `Done`; a request still high in the following IDLE cycle is a new request.
- `Full` flag:
  - Set in INC when `Sp` is all ones; the counter wraps to 0 at that edge.
  - Cleared in DEC.
  - Unchanged otherwise.
- `CntD` = 0 whenever `CntEn` = 0.
- Reset (async, any state): state = IDLE, `LastPop` = 1, `OpPop` = 0, `ErrR` = 0, `Full` = 0.
  - Output values in reset: `CntEn`, `CntD`, `MemWe`, `MemRe`, `Busy`, `Done`, `Err`, `RdValid` = 0; `Empty` = 1 (since `Sp` = 0).
  - A write or read aborted mid-operation leaves stale RAM contents; this is harmless because the stack is empty after reset.

## Timing
- Request high in IDLE at edge k:
  - Successful push: WR in cycle k+1, INC in k+2, DONE in k+3. `Sp` increments at the end of k+2.
  - Successful pop: DEC in k+1, RD in k+2, DONE in k+3 with read data valid.
  - Rejected op: DONE in cycle k+1.
- `Busy` = 1 from cycle k+1 through DONE. IDLE is re-entered in the cycle after DONE, so back-to-back successful ops take 4 cycles each.
- Requests arriving while `Busy` = 1 are ignored, not queued.
- `Full` and `Sp` change on the same edge; `Empty` follows combinationally.

## Test plan
- Reset then push: `ClrN` low, release, `PushReq` for one op.
  - Expect `MemWe` in cycle 1 at `Sp` = 0, `CntEn`/`CntD` = 1 in cycle 2, `Done` in cycle 3 with `Err` = 0.
  - Afterwards `Sp` = 1, `Empty` = 0.
- Fill to overflow (BUSWIDTH = 3):
  - 8 pushes: `Full` rises when `Sp` wraps 7 -> 0.
  - 9th push: `Done` and `Err` in cycle 1, no `MemWe`/`CntEn`, `Sp` stays 0.
- Underflow: pop on an empty stack -> `Done` and `Err` in cycle 1, `RdValid` = 0, no strobes.
- LIFO order: push 0xA, 0xB, 0xC, then 3 pops.
  - `RdValid` data reads 0xC, 0xB, 0xA.
  - `Empty` = 1 at the end.
- Contested arbitration: hold `PushReq` and `PopReq` high together from reset.
  - Grants alternate push, pop, push, pop.
  - Each grant is 4 cycles apart; `Sp` oscillates 0 -> 1 -> 0.
- Reset mid-op: assert `ClrN` during INC of a push.
  - Immediately: state IDLE, `Busy` = 0, `Full` = 0, `Sp` = 0, `Empty` = 1.
  - No `Done` pulse after release.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencing/arbitration controller for a push-down stack.
// Accepts level push/pop requests in IDLE, arbitrates contested requests
// by alternating, and sequences the stack-pointer counter and a 1-cycle
// latency single-port RAM. Owns Full/Empty status and reports rejected
// operations (push on full, pop on empty).
//
// Ports:
//   Clk, ClrN        clock, async active-low clear (shared with SP counter)
//   PushReq, PopReq  level requests, sampled only in IDLE
//   Sp               current stack-pointer counter value
//   CntEn, CntD      counter enable pulse / direction (1 = up)
//   MemWe, MemRe     RAM strobes at address Sp
//   Busy, Done       not-IDLE / one-cycle completion pulse
//   Err, RdValid     qualify Done: rejected op / successful pop data valid
//   Full, Empty      stack status
module stack_ctrl #(
  parameter int BUSWIDTH = 10
) (
  input  logic                Clk,
  input  logic                ClrN,
  input  logic                PushReq,
  input  logic                PopReq,
  input  logic [BUSWIDTH-1:0] Sp,
  output logic                CntEn,
  output logic                CntD,
  output logic                MemWe,
  output logic                MemRe,
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic                RdValid,
  output logic                Full,
  output logic                Empty
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_INC, S_DEC, S_RD, S_DONE
  } state_t;

  state_t r_state;
  logic   r_last_pop;
  logic   r_op_pop;
  logic   r_err;
  logic   r_full;
  logic   w_grant_pop;
  logic   w_empty;

  // Contested requests go to the opposite of the last grant.
  assign w_grant_pop = PopReq && (!PushReq || !r_last_pop);

  // Sp wraps to 0 when the last slot fills, so Full disambiguates.
  assign w_empty = (Sp == '0) && !r_full;

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_state    <= S_IDLE;
      r_last_pop <= 1'b1;
      r_op_pop   <= 1'b0;
      r_err      <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (PushReq || PopReq) begin
            r_last_pop <= w_grant_pop;
            r_op_pop   <= w_grant_pop;
            if (w_grant_pop) begin
              r_err   <= w_empty;
              r_state <= w_empty ? S_DONE : S_DEC;
            end else begin
              r_err   <= r_full;
              r_state <= r_full ? S_DONE : S_WR;
            end
          end
        end
        S_WR:  r_state <= S_INC;
        S_INC: begin
          if (&Sp) r_full <= 1'b1;
          r_state <= S_DONE;
        end
        S_DEC: begin
          r_full  <= 1'b0;
          r_state <= S_RD;
        end
        S_RD:    r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode from registered state/flags only.
  assign CntEn   = (r_state == S_INC) || (r_state == S_DEC);
  assign CntD    = (r_state == S_INC);
  assign MemWe   = (r_state == S_WR);
  assign MemRe   = (r_state == S_RD);
  assign Busy    = (r_state != S_IDLE);
  assign Done    = (r_state == S_DONE);
  assign Err     = (r_state == S_DONE) && r_err;
  assign RdValid = (r_state == S_DONE) && r_op_pop && !r_err;
  assign Full    = r_full;
  assign Empty   = w_empty;

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl with a small stack (BUSWIDTH = 3). Models the
// stack-pointer counter and RAM around the controller, and checks results
// against a LIFO reference model through a scoreboard queue.
module tb_stack_ctrl;
  localparam int BW    = 3;
  localparam int DEPTH = 1 << BW;

  logic          Clk = 1'b0;
  logic          ClrN;
  logic          PushReq, PopReq;
  logic [BW-1:0] Sp;
  logic          CntEn, CntD, MemWe, MemRe, Busy, Done, Err, RdValid, Full, Empty;

  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] wdata, rdata;

  typedef struct {
    logic       err;
    logic       rdv;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[$];
  int         checks = 0;
  int         errors = 0;

  stack_ctrl #(.BUSWIDTH(BW)) dut (
    .Clk(Clk), .ClrN(ClrN), .PushReq(PushReq), .PopReq(PopReq), .Sp(Sp),
    .CntEn(CntEn), .CntD(CntD), .MemWe(MemWe), .MemRe(MemRe), .Busy(Busy),
    .Done(Done), .Err(Err), .RdValid(RdValid), .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  // Stack-pointer counter sharing ClrN with the controller.
  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) Sp <= '0;
    else if (CntEn) Sp <= CntD ? Sp + 1'b1 : Sp - 1'b1;
  end

  // Single-port RAM, 1-cycle read latency.
  always @(posedge Clk) begin
    if (MemWe) mem[Sp] <= wdata;
    if (MemRe) rdata <= mem[Sp];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    ClrN = 1'b0; PushReq = 1'b0; PopReq = 1'b0; wdata = '0;
    #1;
    chk("rst_outs", {CntEn, CntD, MemWe, MemRe, Busy, Done, Err, RdValid, Full}, 9'd0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_sp", Sp, 0);
    @(negedge Clk);
    ClrN = 1'b1;
    model.delete();
    sb.delete();
  endtask

  // One directed operation: push (push=1) of d, or pop (push=0).
  task automatic op(input logic push, input logic [7:0] d);
    exp_t          e, got;
    int            lat, nwe, nre, nen, old_sz;
    logic          done, dir_ok;
    logic [BW-1:0] wesp;
    old_sz = model.size();
    e.data = '0;
    if (push) begin
      e.err = (old_sz == DEPTH);
      e.rdv = 1'b0;
      if (!e.err) model.push_back(d);
    end else begin
      e.err = (old_sz == 0);
      e.rdv = !e.err;
      if (!e.err) e.data = model.pop_back();
    end
    sb.push_back(e);

    @(negedge Clk);
    PushReq = push; PopReq = !push; wdata = d;
    lat = 0; nwe = 0; nre = 0; nen = 0; done = 1'b0; dir_ok = 1'b1; wesp = '0;
    while (!done && lat < 12) begin
      @(negedge Clk);
      lat++;
      if (MemWe) begin nwe++; wesp = Sp; end
      if (MemRe) nre++;
      if (CntEn) begin nen++; if (CntD !== push) dir_ok = 1'b0; end
      if (!CntEn && CntD) dir_ok = 1'b0;
      if (Done) done = 1'b1;
    end
    PushReq = 1'b0; PopReq = 1'b0;
    chk("done_seen", done, 1'b1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("err", Err, got.err);
      chk("rdvalid", RdValid, got.rdv);
      if (got.rdv) chk("rd_data", rdata, got.data);
      chk("latency", lat, got.err ? 1 : 3);
      chk("n_we", nwe, (push && !got.err) ? 1 : 0);
      chk("n_re", nre, (!push && !got.err) ? 1 : 0);
      chk("n_cnten", nen, got.err ? 0 : 1);
      chk("cnt_dir", dir_ok, 1'b1);
      if (push && !got.err) chk("we_addr", wesp, old_sz % DEPTH);
    end
    @(negedge Clk);
    chk("busy_after", Busy, 1'b0);
    chk("sp_after", Sp, model.size() % DEPTH);
    chk("full_after", Full, model.size() == DEPTH);
    chk("empty_after", Empty, model.size() == 0);
  endtask

  initial begin
    int   lat, gap, ndone;
    logic got;

    // Reset then single push.
    do_reset();
    op(1'b1, 8'h11);
    op(1'b0, 8'h00);

    // Underflow on empty stack.
    op(1'b0, 8'h00);

    // LIFO order.
    op(1'b1, 8'h0A);
    op(1'b1, 8'h0B);
    op(1'b1, 8'h0C);
    op(1'b0, 8'h00);
    op(1'b0, 8'h00);
    op(1'b0, 8'h00);

    // Fill to overflow, then drain across the wrap boundary.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 8'h40 + 8'(i));
    op(1'b1, 8'hEE);
    for (int i = 0; i < DEPTH; i++) op(1'b0, 8'h00);
    op(1'b0, 8'h00);

    // Contested arbitration: both held from reset -> push, pop, push, pop.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.err = 1'b0; e.rdv = (i % 2 == 1); e.data = 8'h5A;
      sb.push_back(e);
    end
    @(negedge Clk);
    PushReq = 1'b1; PopReq = 1'b1; wdata = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      lat = 0; got = 1'b0;
      while (!got && lat < 12) begin
        @(negedge Clk);
        lat++;
        if (Done) got = 1'b1;
      end
      chk("arb_done_seen", got, 1'b1);
      gap = (i == 0) ? 3 : 4;
      chk("arb_gap", lat, gap);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("arb_err", Err, e.err);
        chk("arb_rdvalid", RdValid, e.rdv);
        if (e.rdv) chk("arb_data", rdata, e.data);
      end
      chk("arb_sp", Sp, (i % 2 == 0) ? 1 : 0);
    end
    PushReq = 1'b0; PopReq = 1'b0;

    // Reset during INC of a push.
    do_reset();
    @(negedge Clk);
    PushReq = 1'b1; wdata = 8'h77;
    lat = 0;
    while (!CntEn && lat < 12) begin
      @(negedge Clk);
      lat++;
    end
    chk("inc_reached", {CntEn, CntD}, 2'b11);
    ClrN = 1'b0; PushReq = 1'b0;
    #1;
    chk("mid_busy", Busy, 1'b0);
    chk("mid_full", Full, 1'b0);
    chk("mid_sp", Sp, 0);
    chk("mid_empty", Empty, 1'b1);
    @(negedge Clk);
    ClrN = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Done || Busy) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    chk("sp_after_rst", Sp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
